// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: FSM states and the 38-bit write-back bundle.
// The packed bundle's field order gives the bit layout seen by write-back.
package mem_access_stage_pkg;

    localparam int WB_W = 38;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Declared MSB first: pc[37:22], result[21:6], rd[5:3], reg_write[2], is_load[1], valid[0]
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] result;
        logic [2:0]  rd;
        logic        reg_write;
        logic        is_load;
        logic        valid;
    } wb_t;

    function automatic wb_t mk_wb(input logic [15:0] pc, input logic [15:0] result,
                                  input logic [2:0] rd, input logic reg_write,
                                  input logic is_load);
        wb_t b;
        b.pc        = pc;
        b.result    = result;
        b.rd        = rd;
        b.reg_write = reg_write;
        b.is_load   = is_load;
        b.valid     = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Execute-side, data-memory and write-back signals of the memory-access stage.
// slave = the stage itself; master = the surrounding pipeline / memory environment.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic            ex_valid;
    logic            ex_ready;
    logic [15:0]     ex_alu_result;
    logic [15:0]     ex_store_data;
    logic [2:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [15:0]     ex_pc;

    logic            dmem_req;
    logic            dmem_we;
    logic [15:0]     dmem_addr;
    logic [15:0]     dmem_wdata;
    logic            dmem_ack;
    logic [15:0]     dmem_rdata;

    logic [WB_W-1:0] wb_data;
    logic            mem_err;

    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_pc, dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, mem_err
    );

    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_pc, dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, mem_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU results retire in 1 cycle, loads/stores via req/ack
// with a timeout. Latency 1 (ALU) / 2+waits (memory); ex_ready low while an access is outstanding.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               resetn,
    mem_access_stage_if.slave  bus
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] pc_q, pc_d;
    logic [2:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic [7:0]  timer_q, timer_d;
    logic        err_q, err_d;
    wb_t         wb_q, wb_d;

    logic accept, is_mem, illegal, timeout_hit;

    assign accept      = bus.ex_valid && (state_q == ST_IDLE);
    assign is_mem      = bus.ex_mem_read || bus.ex_mem_write;
    assign illegal     = bus.ex_mem_read && bus.ex_mem_write;
    assign timeout_hit = (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_mem && !illegal) state_d = ST_WAIT;
            ST_WAIT: if (bus.dmem_ack || timeout_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs and latched access context; every non-retiring cycle emits a bubble.
    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        timer_d = timer_q;
        err_d   = err_q;
        wb_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else if (is_mem) begin
                        req_d   = 1'b1;
                        we_d    = bus.ex_mem_write;
                        addr_d  = bus.ex_alu_result;
                        wdata_d = bus.ex_store_data;
                        pc_d    = bus.ex_pc;
                        rd_d    = bus.ex_rd;
                        rw_d    = bus.ex_reg_write;
                        timer_d = 8'd0;
                    end else begin
                        wb_d = mk_wb(bus.ex_pc, bus.ex_alu_result, bus.ex_rd,
                                     bus.ex_reg_write, 1'b0);
                    end
                end
            end
            ST_WAIT: begin
                if (bus.dmem_ack) begin
                    req_d   = 1'b0;
                    timer_d = 8'd0;
                    if (we_q) wb_d = mk_wb(pc_q, addr_q, rd_q, 1'b0, 1'b0);
                    else      wb_d = mk_wb(pc_q, bus.dmem_rdata, rd_q, rw_q, 1'b1);
                end else if (timeout_hit) begin
                    // Abandoned access retires as a harmless valid bundle so write-back stays in step.
                    req_d   = 1'b0;
                    timer_d = 8'd0;
                    err_d   = 1'b1;
                    wb_d    = mk_wb(pc_q, 16'h0000, rd_q, 1'b0, 1'b0);
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            timer_q <= '0;
            err_q   <= 1'b0;
            wb_q    <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
        end
    end

    assign bus.ex_ready   = (state_q == ST_IDLE);
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.wb_data    = wb_q;
    assign bus.mem_err    = err_q;

endmodule
